// File: rtl/key_conditioner.sv
// key_conditioner: per-channel key input conditioning for a small game controller.
//   Each raw key level is synchronised, debounced, and turned into press/release
//   pulses plus an optional auto-repeat pulse train while the key is held.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   key_raw      asynchronous raw key levels (1 = pressed)
//   repeat_en    per-channel auto-repeat enable
//   key_state    debounced key level
//   key_press    one-cycle pulse on debounced 0->1
//   key_release  one-cycle pulse on debounced 1->0
//   key_rep      one-cycle auto-repeat pulse
//   any_press    OR of key_press and key_rep over all channels
module key_conditioner #(
    parameter int unsigned N_CH          = 3,
    parameter int unsigned DB_CYCLES     = 16,
    parameter int unsigned REPEAT_DELAY  = 40,
    parameter int unsigned REPEAT_PERIOD = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] key_raw,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] key_state,
    output logic [N_CH-1:0] key_press,
    output logic [N_CH-1:0] key_release,
    output logic [N_CH-1:0] key_rep,
    output logic            any_press
);

    localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST       = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE        = DB_W'(1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LD = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE       = RPT_W'(1);

    logic [N_CH-1:0]            r_sync1;
    logic [N_CH-1:0]            r_sync2;
    // Qualified level; key_state is this value one cycle later so that the
    // press/release pulses can be formed from two registered levels.
    logic [N_CH-1:0]            r_db;
    logic [N_CH-1:0][DB_W-1:0]  r_db_cnt;
    logic [N_CH-1:0][RPT_W-1:0] r_rpt_cnt;
    logic [N_CH-1:0]            r_key_state;
    logic [N_CH-1:0]            r_key_press;
    logic [N_CH-1:0]            r_key_release;
    logic [N_CH-1:0]            r_key_rep;
    logic                       r_any_press;

    logic [N_CH-1:0]            w_db_d;
    logic [N_CH-1:0][DB_W-1:0]  w_db_cnt_d;
    logic [N_CH-1:0][RPT_W-1:0] w_rpt_cnt_d;
    logic [N_CH-1:0]            w_press_d;
    logic [N_CH-1:0]            w_release_d;
    logic [N_CH-1:0]            w_rep_d;

    always_comb begin
        w_db_d      = r_db;
        w_db_cnt_d  = '0;
        w_rpt_cnt_d = '0;
        w_rep_d     = '0;
        w_press_d   = r_db & ~r_key_state;
        w_release_d = ~r_db & r_key_state;
        for (int unsigned i = 0; i < N_CH; i++) begin
            // Debounce: count consecutive mismatches; toggle on the DB_CYCLES-th.
            if (r_sync2[i] != r_db[i]) begin
                if (r_db_cnt[i] == DB_LAST) begin
                    w_db_d[i] = r_sync2[i];
                end else begin
                    w_db_cnt_d[i] = r_db_cnt[i] + DB_ONE;
                end
            end
            // Repeat: runs off the qualified level so the first pulse lands exactly
            // REPEAT_DELAY cycles after the press pulse and never with press/release.
            w_rpt_cnt_d[i] = RPT_DELAY_LD;
            if (r_db[i] && repeat_en[i] && !w_press_d[i]) begin
                if (r_rpt_cnt[i] == '0) begin
                    w_rep_d[i]     = 1'b1;
                    w_rpt_cnt_d[i] = RPT_PERIOD_LD;
                end else begin
                    w_rpt_cnt_d[i] = r_rpt_cnt[i] - RPT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_db          <= '0;
            r_db_cnt      <= '0;
            r_rpt_cnt     <= {N_CH{RPT_DELAY_LD}};
            r_key_state   <= '0;
            r_key_press   <= '0;
            r_key_release <= '0;
            r_key_rep     <= '0;
            r_any_press   <= 1'b0;
        end else begin
            r_sync1       <= key_raw;
            r_sync2       <= r_sync1;
            r_db          <= w_db_d;
            r_db_cnt      <= w_db_cnt_d;
            r_rpt_cnt     <= w_rpt_cnt_d;
            r_key_state   <= r_db;
            r_key_press   <= w_press_d;
            r_key_release <= w_release_d;
            r_key_rep     <= w_rep_d;
            r_any_press   <= |(w_press_d | w_rep_d);
        end
    end

    assign key_state   = r_key_state;
    assign key_press   = r_key_press;
    assign key_release = r_key_release;
    assign key_rep     = r_key_rep;
    assign any_press   = r_any_press;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus randomized key activity for
// key_conditioner, checked every cycle against a history-based reference model.
module tb_key_conditioner;

    localparam int N  = 3;
    localparam int DB = 16;
    localparam int RD = 40;
    localparam int RP = 10;

    logic         clk;
    logic         rst;
    logic [N-1:0] key_raw;
    logic [N-1:0] repeat_en;
    logic [N-1:0] key_state;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_rep;
    logic         any_press;

    key_conditioner #(
        .N_CH          (N),
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .repeat_en   (repeat_en),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_rep     (key_rep),
        .any_press   (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a key level flips once the last DB synchronised samples
    // (raw samples from two edges back) all disagree with it; outputs appear one
    // edge later. Repeats are timed from the last edge the hold condition failed.
    int           cyc = 0;
    logic [N-1:0] hist[$];
    logic [N-1:0] m_lvl, m_state, new_lvl;
    logic [N-1:0] e_state, e_press, e_rel, e_rep;
    logic         e_any;
    int           anchor[N];
    int           m_d;
    bit           all_diff;

    // Event log of DUT pulses, used by the directed scenarios.
    int ev_press[N], ev_rel[N], ev_rep[N];
    int first_press[N], first_rel[N], first_rep[N];

    task automatic clear_ev();
        for (int c = 0; c < N; c++) begin
            ev_press[c] = 0; ev_rel[c] = 0; ev_rep[c] = 0;
            first_press[c] = -1; first_rel[c] = -1; first_rep[c] = -1;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            hist.delete();
            for (int k = 0; k < DB + 2; k++) hist.push_back('0);
            m_lvl = '0; m_state = '0;
            e_state = '0; e_press = '0; e_rel = '0; e_rep = '0; e_any = 1'b0;
            for (int c = 0; c < N; c++) anchor[c] = cyc;
        end else begin
            hist.push_back(key_raw);
            void'(hist.pop_front());
            new_lvl = m_lvl;
            for (int c = 0; c < N; c++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++) if (hist[k][c] == m_lvl[c]) all_diff = 1'b0;
                if (all_diff) new_lvl[c] = ~m_lvl[c];
            end
            e_state = m_lvl;
            e_press = m_lvl & ~m_state;
            e_rel   = ~m_lvl & m_state;
            for (int c = 0; c < N; c++) begin
                if (m_lvl[c] && repeat_en[c] && !e_press[c]) begin
                    m_d = cyc - anchor[c];
                    e_rep[c] = (m_d >= RD) && (((m_d - RD) % RP) == 0);
                end else begin
                    anchor[c] = cyc;
                    e_rep[c]  = 1'b0;
                end
            end
            e_any   = |(e_press | e_rep);
            m_state = m_lvl;
            m_lvl   = new_lvl;
        end
        #1;
        check_val("outputs", {19'd0, any_press, key_rep, key_release, key_press, key_state},
                  {19'd0, e_any, e_rep, e_rel, e_press, e_state});
        for (int c = 0; c < N; c++) begin
            if (key_press[c] === 1'b1) begin
                ev_press[c]++;
                if (first_press[c] < 0) first_press[c] = cyc;
            end
            if (key_release[c] === 1'b1) begin
                ev_rel[c]++;
                if (first_rel[c] < 0) first_rel[c] = cyc;
            end
            if (key_rep[c] === 1'b1) begin
                ev_rep[c]++;
                if (first_rep[c] < 0) first_rep[c] = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int e0, f, p, er, sel;
    int hold[N];

    initial begin
        rst = 1'b0; key_raw = '0; repeat_en = '0;
        clear_ev();
        repeat (3) tick();
        check_val("reset_outputs", {key_rep, key_release, key_press, key_state, any_press}, 0);
        rst = 1'b1;
        repeat (5) tick();

        // Single press on channel 2: latency DB+2, one pulse, other channels quiet.
        clear_ev();
        key_raw = 3'b100; e0 = cyc + 1;
        repeat (30) tick();
        check_val("press2_latency", first_press[2] - e0, DB + 2);
        check_val("press2_count", ev_press[2], 1);
        check_val("other_press", ev_press[0] + ev_press[1], 0);
        check_val("state_after_press", key_state, 3'b100);
        key_raw = '0;
        repeat (30) tick();
        check_val("release2_count", ev_rel[2], 1);

        // Glitch one cycle shorter than DB is rejected; DB cycles qualifies.
        clear_ev();
        key_raw[0] = 1'b1;
        repeat (DB - 1) tick();
        key_raw[0] = 1'b0;
        repeat (40) tick();
        check_val("glitch_rejected", ev_press[0] + ev_rel[0], 0);
        clear_ev();
        key_raw[0] = 1'b1; e0 = cyc + 1;
        repeat (DB) tick();
        key_raw[0] = 1'b0; f = cyc + 1;
        repeat (40) tick();
        check_val("min_pulse_press", first_press[0] - e0, DB + 2);
        check_val("min_pulse_release", first_rel[0] - f, DB + 2);

        // Bounce every 13 cycles, then held high: one press, no release.
        clear_ev();
        for (int k = 0; k < 200; k++) begin
            if (k % 13 == 0) key_raw[2] = ~key_raw[2];
            tick();
        end
        key_raw[2] = 1'b1;
        repeat (40) tick();
        check_val("bounce_press", ev_press[2], 1);
        check_val("bounce_release", ev_rel[2], 0);
        key_raw = '0;
        repeat (30) tick();

        // Auto-repeat on channel 1 over 100 held cycles, then with repeat disabled.
        clear_ev();
        repeat_en = 3'b010; key_raw[1] = 1'b1;
        repeat (30) tick();
        p = first_press[1];
        while (cyc < p + 100) tick();
        check_val("repeat_count", ev_rep[1], 7);
        check_val("repeat_first", first_rep[1] - p, RD);
        key_raw = '0;
        repeat (30) tick();
        repeat_en = '0;
        clear_ev();
        key_raw[1] = 1'b1;
        repeat (30) tick();
        p = first_press[1];
        while (cyc < p + 100) tick();
        check_val("repeat_disabled", ev_rep[1], 0);
        check_val("press_no_repeat", ev_press[1], 1);
        key_raw = '0;
        repeat (30) tick();

        // Two channels pressed on the same edge.
        clear_ev();
        key_raw = 3'b011;
        for (int k = 0; k < 30 && key_press == '0; k++) tick();
        check_val("dual_press", key_press, 3'b011);
        check_val("dual_any", any_press, 1);
        tick();
        check_val("dual_any_drop", any_press, 0);
        key_raw = '0;
        repeat (30) tick();

        // Reset mid-hold with repeat active; key re-qualified afterwards.
        clear_ev();
        repeat_en = 3'b100; key_raw = 3'b100;
        repeat (DB + 2 + 45) tick();
        check_val("rep_before_rst", ev_rep[2], 1);
        rst = 1'b0;
        clear_ev();
        repeat (5) begin
            tick();
            check_val("rst_outputs", {key_rep, key_release, key_press, key_state, any_press}, 0);
        end
        rst = 1'b1; er = cyc + 1;
        repeat (80) tick();
        check_val("rst_repress", first_press[2] - er, DB + 2);
        check_val("rst_no_release", ev_rel[2], 0);
        check_val("rst_first_rep", first_rep[2] - first_press[2], RD);
        key_raw = '0; repeat_en = '0;
        repeat (30) tick();

        // Randomized activity: mixed short bounces and long holds, enable flips,
        // occasional single-cycle resets; the model checks every cycle.
        for (int c = 0; c < N; c++) hold[c] = 1;
        for (int n = 0; n < 2500; n++) begin
            for (int c = 0; c < N; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    key_raw[c] = ~key_raw[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 130))
                                                          : int'($urandom_range(1, 24));
                end
            end
            if ($urandom_range(0, 63) == 0) begin
                sel = int'($urandom_range(0, N - 1));
                repeat_en[sel] = ~repeat_en[sel];
            end
            rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst = 1'b1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
